// File: rtl/counter_cmd_sequencer_if.sv
// counter_cmd_sequencer_if: valid/ready command channel into the counter command sequencer.
//   cmd_valid : command present (master -> slave)
//   cmd_ready : slave can accept a command (slave -> master)
//   cmd_op    : 00 LOAD, 01 UP, 10 DOWN, 11 HOLD
//   cmd_arg   : LOAD value (low DW bits) or repeat count (low AW bits)
interface counter_cmd_sequencer_if #(
    parameter int DW = 8,
    parameter int AW = 8
) ();
    localparam int WA = (DW > AW) ? DW : AW;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [WA-1:0] cmd_arg;
    modport master (output cmd_valid, cmd_op, cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_arg, output cmd_ready);
endinterface

// File: rtl/counter_cmd_sequencer.sv
// counter_cmd_sequencer: queues LOAD/UP/DOWN/HOLD commands and plays them onto an up/down/load counter, checking its output.
//   clk, rst_n  : clock, synchronous active-low reset
//   cmd         : command channel (slave side), cmd_ready = FIFO not full
//   ld_en, en, updwn, datain : registered counter control pins
//   dataout_fb  : counter output fed back for checking
//   busy        : executing or commands pending
//   done        : high during the last control cycle of each command
//   err_clr     : clears err / err_cnt (wins over a same-cycle mismatch)
//   err, err_cnt: sticky mismatch flag and saturating mismatch count
module counter_cmd_sequencer #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    counter_cmd_sequencer_if.slave cmd,
    output logic                   ld_en,
    output logic                   en,
    output logic                   updwn,
    output logic [DW-1:0]          datain,
    input  logic [DW-1:0]          dataout_fb,
    output logic                   busy,
    output logic                   done,
    input  logic                   err_clr,
    output logic                   err,
    output logic [7:0]             err_cnt
);
    localparam int WA = (DW > AW) ? DW : AW;
    localparam int PW = $clog2(DEPTH);
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t        state;
    logic [1:0]    op_q  [DEPTH];
    logic [WA-1:0] arg_q [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   cnt;
    logic [AW-1:0] rem;
    logic [DW-1:0] exp_val;
    logic          armed;

    logic          full, empty, push, pop, last;
    logic [1:0]    head_op;
    logic [WA-1:0] head_arg;
    logic          h_load, h_zero;
    logic [AW-1:0] h_rem;

    assign full     = cnt == (PW+1)'(DEPTH);
    assign empty    = cnt == '0;
    assign push     = cmd.cmd_valid && !full;
    assign last     = state == EXEC && rem == AW'(1);
    // Pop from IDLE, or on the last cycle of a command so the next one starts without a bubble.
    assign pop      = !empty && (state == IDLE || last);
    assign head_op  = op_q[rd_ptr];
    assign head_arg = arg_q[rd_ptr];
    assign h_load   = head_op == OP_LOAD;
    // A zero repeat count still occupies one cycle, with every control low.
    assign h_zero   = !h_load && head_arg[AW-1:0] == '0;
    assign h_rem    = (h_load || h_zero) ? AW'(1) : head_arg[AW-1:0];

    assign cmd.cmd_ready = !full;
    assign busy          = state == EXEC || !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                op_q[wr_ptr]  <= cmd.cmd_op;
                arg_q[wr_ptr] <= cmd.cmd_arg;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            rem    <= '0;
            ld_en  <= 1'b0;
            en     <= 1'b0;
            updwn  <= 1'b0;
            datain <= '0;
            done   <= 1'b0;
        end else if (pop) begin
            state <= EXEC;
            rem   <= h_rem;
            ld_en <= h_load;
            en    <= !h_zero && (head_op == OP_UP || head_op == OP_DOWN);
            updwn <= !h_zero && head_op == OP_DOWN;
            done  <= h_rem == AW'(1);
            if (h_load) datain <= head_arg[DW-1:0];
        end else if (last) begin
            state <= IDLE;
            ld_en <= 1'b0;
            en    <= 1'b0;
            updwn <= 1'b0;
            done  <= 1'b0;
        end else if (state == EXEC) begin
            rem  <= rem - 1'b1;
            done <= rem == AW'(2);
        end
    end

    // Shadow counter tracks what the real counter does with the controls presented this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_val <= '0;
            armed   <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (ld_en) begin
                exp_val <= datain;
                armed   <= 1'b1;
            end else if (en) begin
                exp_val <= updwn ? exp_val - 1'b1 : exp_val + 1'b1;
            end
            if (err_clr) begin
                err     <= 1'b0;
                err_cnt <= '0;
            end else if (armed && dataout_fb != exp_val) begin
                err     <= 1'b1;
                err_cnt <= err_cnt + 8'(err_cnt != 8'hFF);
            end
        end
    end
endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// tb_counter_cmd_sequencer: directed, table-driven bench with a behavioural counter on the feedback path.
module tb_counter_cmd_sequencer;
    localparam logic [1:0] LOAD = 2'b00, UP = 2'b01, DOWN = 2'b10, HOLD = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld_en, en, updwn, busy, done, err, err_clr = 1'b0;
    logic [7:0] datain, dataout_fb, err_cnt, cnt_m, frc_val = 8'h00;
    logic       frc = 1'b0;
    int         n_vec = 0, n_err = 0;
    int         n_ld = 0, n_up = 0, n_dn = 0, n_done = 0;

    counter_cmd_sequencer_if #(.DW(8), .AW(8)) cmd ();

    counter_cmd_sequencer #(.DW(8), .AW(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd),
        .ld_en(ld_en), .en(en), .updwn(updwn), .datain(datain),
        .dataout_fb(dataout_fb), .busy(busy), .done(done),
        .err_clr(err_clr), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst_n) cnt_m <= 8'h00;
        else if (ld_en) cnt_m <= datain;
        else if (en) cnt_m <= updwn ? cnt_m - 8'h01 : cnt_m + 8'h01;

    assign dataout_fb = frc ? frc_val : cnt_m;

    always @(negedge clk) begin
        n_ld   <= n_ld + int'(ld_en);
        n_up   <= n_up + int'(en && !updwn);
        n_dn   <= n_dn + int'(en && updwn);
        n_done <= n_done + int'(done);
    end

    typedef struct {
        logic [1:0] op;
        logic [7:0] arg;
        int         ld, up, dn, dn_pulses;
        logic [7:0] final_val;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] arg);
        int i;
        @(negedge clk);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = op;
        cmd.cmd_arg   = arg;
        for (i = 0; i < 400 && !cmd.cmd_ready; i++) @(negedge clk);
        if (i == 400) chk("push_timeout", 1, 0);
        @(posedge clk);
        #1 cmd.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (i == 600) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_sig(input int which);
        int i;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (which == 0 ? ld_en : en) break;
        end
        if (i == 50) chk("wait_timeout", 1, 0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v[9];
        int   s_ld, s_up, s_dn, s_done, stall;
        logic prev_done;
        v[0] = '{LOAD, 8'h5A, 1, 0, 0, 1, 8'h5A};
        v[1] = '{UP,   8'h03, 0, 3, 0, 1, 8'h5D};
        v[2] = '{LOAD, 8'h01, 1, 0, 0, 1, 8'h01};
        v[3] = '{DOWN, 8'h02, 0, 0, 2, 1, 8'hFF};
        v[4] = '{UP,   8'h01, 0, 1, 0, 1, 8'h00};
        v[5] = '{HOLD, 8'h05, 0, 0, 0, 1, 8'h00};
        v[6] = '{UP,   8'h00, 0, 0, 0, 1, 8'h00};
        v[7] = '{LOAD, 8'hFF, 1, 0, 0, 1, 8'hFF};
        v[8] = '{UP,   8'h01, 0, 1, 0, 1, 8'h00};
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = 2'b00;
        cmd.cmd_arg   = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ld_en", ld_en, 0);
        chk("rst_en", en, 0);
        chk("rst_updwn", updwn, 0);
        chk("rst_datain", datain, 8'h00);
        chk("rst_ready", cmd.cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 8'h00);
        rst_n = 1'b1;

        // LOAD 5A then UP 3, cycle by cycle
        push(LOAD, 8'h5A);
        push(UP, 8'h03);
        wait_sig(0);
        chk("seq_datain", datain, 8'h5A);
        chk("seq_ld_done", done, 1);
        chk("seq_ld_en0", en, 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("seq_en", en, 1);
            chk("seq_updwn", updwn, 0);
            chk("seq_ld_en", ld_en, 0);
            chk("seq_done", done, k == 3);
            chk("seq_fb", dataout_fb, 8'h59 + 8'(k));
        end
        @(negedge clk);
        chk("seq_en_off", en, 0);
        chk("seq_fb_end", dataout_fb, 8'h5D);
        @(negedge clk);
        chk("seq_err", err, 0);

        // one command at a time from the table
        foreach (v[i]) begin
            s_ld = n_ld; s_up = n_up; s_dn = n_dn; s_done = n_done;
            push(v[i].op, v[i].arg);
            wait_idle();
            @(negedge clk);
            chk($sformatf("v%0d_ld", i), n_ld - s_ld, v[i].ld);
            chk($sformatf("v%0d_up", i), n_up - s_up, v[i].up);
            chk($sformatf("v%0d_dn", i), n_dn - s_dn, v[i].dn);
            chk($sformatf("v%0d_done", i), n_done - s_done, v[i].dn_pulses);
            chk($sformatf("v%0d_val", i), dataout_fb, v[i].final_val);
            chk($sformatf("v%0d_err", i), err, 0);
        end

        // FIFO fill behind a long HOLD; no push-through while full
        s_done = n_done;
        push(HOLD, 8'd16);
        push(UP, 8'h01);
        push(UP, 8'h01);
        push(DOWN, 8'h01);
        push(LOAD, 8'h33);
        @(negedge clk);
        chk("full_ready", cmd.cmd_ready, 0);
        chk("full_busy", busy, 1);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = UP;
        cmd.cmd_arg   = 8'h02;
        stall = 0;
        prev_done = 1'b0;
        for (int i = 0; i < 100 && !cmd.cmd_ready; i++) begin
            stall++;
            prev_done = done;
            @(negedge clk);
        end
        chk("full_stall", stall, 13);
        chk("full_hold_done", prev_done, 1);
        chk("full_next_en", en, 1);
        @(posedge clk);
        #1 cmd.cmd_valid = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("full_val", dataout_fb, 8'h35);
        chk("full_done", n_done - s_done, 6);
        chk("full_err", err, 0);

        // mismatch detection, clear, saturation, clear priority
        push(LOAD, 8'h10);
        wait_sig(0);
        @(negedge clk);
        frc = 1'b1;
        frc_val = 8'h11;
        repeat (2) @(negedge clk);
        frc = 1'b0;
        chk("mis_err", err, 1);
        chk("mis_cnt", err_cnt, 8'd2);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_err", err, 0);
        chk("clr_cnt", err_cnt, 8'd0);
        repeat (3) @(negedge clk);
        chk("match_err", err, 0);
        frc = 1'b1;
        repeat (300) @(negedge clk);
        chk("sat_cnt", err_cnt, 8'hFF);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        frc = 1'b0;
        chk("prio_err", err, 0);
        chk("prio_cnt", err_cnt, 8'd0);

        // reset in the middle of a long UP
        s_done = n_done;
        push(UP, 8'd200);
        wait_sig(1);
        repeat (49) @(negedge clk);
        chk("mid_en", en, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_en", en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", cmd.cmd_ready, 1);
        chk("abort_pulses", n_done - s_done, 0);
        rst_n = 1'b1;
        frc = 1'b1;
        frc_val = 8'hA5;
        repeat (4) @(negedge clk);
        frc = 1'b0;
        chk("unarmed_err", err, 0);
        chk("unarmed_cnt", err_cnt, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/counter_cmd_sequencer.md
Name: counter_cmd_sequencer

Overview:
- Command-driven stimulus stage placed directly upstream of the 8-bit up/down/load counter; drives its ld_en, en, updwn and datain pins.
- Accepts LOAD/UP/DOWN/HOLD commands through a valid/ready interface into a small FIFO and executes them as cycle-exact control sequences.
- Keeps a shadow model of the expected counter value, compares it against the counter's dataout every cycle, and reports mismatches through a sticky flag and a counter.

Parameters:
DW, 8, counter data width (datain, dataout_fb, exp_val)
AW, 8, width of command argument repeat count (used when op is not LOAD)
DEPTH, 4, command FIFO depth (power of two, >=2)

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  synchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept; equals !full
cmd_op  in  2  00 LOAD, 01 UP, 10 DOWN, 11 HOLD
cmd_arg  in  max(DW,AW)  LOAD: value in low DW bits; others: repeat count in low AW bits
ld_en  out  1  counter load strobe
en  out  1  counter count enable
updwn  out  1  0 = count up, 1 = count down
datain  out  DW  counter load value
dataout_fb  in  DW  counter output, fed back
busy  out  1  FSM in EXEC or FIFO non-empty
done  out  1  one-cycle pulse on the last cycle of each command
err_clr  in  1  clears err and err_cnt
err  out  1  sticky mismatch flag
err_cnt  out  8  saturating mismatch count

Behaviour:
- Reset (rst_n=0 at posedge):
  - FIFO emptied; FSM to IDLE.
  - ld_en, en, updwn, datain, done, err, err_cnt, exp_val and armed all cleared to 0.
  - cmd_ready=1 from the first cycle after reset.
  - Reset mid-command aborts the command; no done pulse is issued.
- Push: FIFO accepts when cmd_valid & cmd_ready. When full, cmd_ready=0 even if a pop occurs in the same cycle (no push-through).
- FSM IDLE: all control outputs 0. If the FIFO is non-empty, pop the head, latch op/arg, set rem=arg (LOAD: rem=1; arg=0 treated as rem=1 with all controls 0), and go to EXEC.
  - Control outputs are registered, so the first controlled cycle is the cycle after the pop: 1-cycle latency from IDLE.
- FSM EXEC, one control cycle per clock:
  - LOAD: ld_en=1, en=0, datain=arg.
  - UP: en=1, updwn=0.
  - DOWN: en=1, updwn=1.
  - HOLD: en=0, ld_en=0.
  - datain holds its last loaded value outside LOAD cycles.
- Command retirement:
  - rem decrements each cycle; the last cycle is rem==1, where done=1.
  - If the FIFO is non-empty on the last cycle, the next command is popped and starts on the following cycle (back-to-back, no bubble).
  - Otherwise the FSM returns to IDLE.
- Shadow model, updated at the same edge the counter updates:
  - LOAD cycle: exp_val<=arg and armed<=1.
  - UP cycle: exp_val<=exp_val+1, mod 2^DW (FF->00 wraps).
  - DOWN cycle: exp_val<=exp_val-1, mod 2^DW (00->FF wraps).
  - HOLD, idle and zero-count cycles: exp_val unchanged.
- Checker:
  - At each posedge with armed=1, if dataout_fb != exp_val then err<=1 and err_cnt<=err_cnt+1, saturating at FF.
  - No checking before the first LOAD after reset.
  - err_clr takes priority over a same-cycle mismatch: err and err_cnt are cleared.
- busy=0 only when in IDLE with an empty FIFO.

Test Plan:
1. Hold rst_n=0 for 3 cycles -> ld_en=en=updwn=0, datain=00, cmd_ready=1, busy=0, err=0, err_cnt=0.
2. Push LOAD 5A, then UP 3, with a behavioural counter on dataout_fb -> one cycle of ld_en=1 with datain=5A, then 3 consecutive cycles of en=1, updwn=0 with no gap; dataout_fb sequence 5A,5B,5C,5D; done pulses twice; err=0.
3. Push LOAD 01, then DOWN 2 -> dataout_fb 00 then FF; exp_val=FF; err=0 (wrap-around).
4. With the FSM idle, push HOLD 10 then 4 more commands back-to-back -> HOLD popped, FIFO holds 4, cmd_ready=0 for the remainder of the HOLD; the 5th push stalls until the first pop after HOLD retires.
5. Push LOAD 10; on the next cycle force dataout_fb=11 for 2 cycles -> err=1 and err_cnt=2; pulse err_clr -> err=0, err_cnt=0; matching dataout_fb afterwards keeps err at 0.
6. Push UP 200 and assert rst_n=0 after 50 count cycles -> at the next edge en=0, FIFO empty, busy=0, armed=0, no done pulse.
